// File: rtl/dense_seq_ctrl.sv
// rtl/dense_seq_ctrl.sv - dense-layer sequencer: address generation, biased MAC, saturating handshake output
module dense_seq_ctrl #(
  parameter int fixed = 32,
  parameter int FRAC  = 16,
  parameter int IW    = 7,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IW-1:0]    cfg_nb_input,
  input  logic [IW-1:0]    cfg_nb_neurons,
  input  logic [IW-1:0]    cfg_stride,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [IW-1:0]    b_addr,
  output logic [AW-1:0]    w_addr,
  output logic [IW-1:0]    x_addr,
  input  logic [fixed-1:0] b_data,
  input  logic [fixed-1:0] w_data,
  input  logic [fixed-1:0] x_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [IW-1:0]    y_idx,
  output logic [fixed-1:0] y_data
);

  localparam int PW   = 2 * fixed;
  localparam int ACCW = PW + 8;
  localparam logic [fixed-1:0] SAT_MAX = {1'b0, {(fixed-1){1'b1}}};
  localparam logic [fixed-1:0] SAT_MIN = {1'b1, {(fixed-1){1'b0}}};
  localparam logic [IW-1:0]    ONE     = {{(IW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_OUT} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          nb_in_q, nb_in_d;
  logic [IW-1:0]          nb_neu_q, nb_neu_d;
  logic [IW-1:0]          stride_q, stride_d;
  logic [IW-1:0]          n_q, n_d;
  logic [IW-1:0]          k_q, k_d;
  logic [AW-1:0]          waddr_q, waddr_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic                   done_q, done_d;

  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] bias_ext;
  logic signed [ACCW-1:0] shr;
  logic [ACCW-fixed:0]    shr_hi;
  logic [fixed-1:0]       sat;

  // Read data arrives one cycle after its strobe, so products always lag the address by one k.
  assign prod     = $signed(w_data) * $signed(x_data);
  assign prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};
  assign bias_ext = {{(ACCW-fixed){b_data[fixed-1]}}, b_data} <<< FRAC;
  assign shr      = acc_q >>> FRAC;
  assign shr_hi   = shr[ACCW-1:fixed-1];
  assign sat      = (&shr_hi || ~|shr_hi) ? shr[fixed-1:0] : (shr[ACCW-1] ? SAT_MIN : SAT_MAX);

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign rd_en   = (state_q == S_BIAS) || (state_q == S_MAC);
  assign b_addr  = n_q;
  assign w_addr  = waddr_q;
  assign x_addr  = k_q;
  assign y_valid = (state_q == S_OUT);
  assign y_idx   = n_q;
  assign y_data  = (state_q == S_OUT) ? sat : '0;

  // Next-state, counter, address and accumulator updates for the layer walk.
  always_comb begin
    state_d  = state_q;
    nb_in_d  = nb_in_q;
    nb_neu_d = nb_neu_q;
    stride_d = stride_q;
    n_d      = n_q;
    k_d      = k_q;
    waddr_d  = waddr_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          nb_in_d  = cfg_nb_input;
          nb_neu_d = cfg_nb_neurons;
          stride_d = cfg_stride;
          if (cfg_nb_input == '0 || cfg_nb_neurons == '0) begin
            done_d = 1'b1;
          end else begin
            n_d     = '0;
            state_d = S_BIAS;
          end
        end
      end
      S_BIAS: begin
        k_d     = '0;
        waddr_d = AW'(n_q);
        state_d = S_MAC;
      end
      S_MAC: begin
        if (k_q == '0) acc_d = bias_ext;
        else           acc_d = acc_q + prod_ext;
        // The last k keeps its addresses so they hold while rd_en is low.
        if (k_q == nb_in_q - ONE) begin
          state_d = S_DRAIN;
        end else begin
          k_d     = k_q + ONE;
          waddr_d = waddr_q + AW'(stride_q);
        end
      end
      S_DRAIN: begin
        acc_d   = acc_q + prod_ext;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (y_ready) begin
          if (n_q == nb_neu_q - ONE) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            n_d     = n_q + ONE;
            state_d = S_BIAS;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial layer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      nb_in_q  <= '0;
      nb_neu_q <= '0;
      stride_q <= '0;
      n_q      <= '0;
      k_q      <= '0;
      waddr_q  <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      nb_in_q  <= nb_in_d;
      nb_neu_q <= nb_neu_d;
      stride_q <= stride_d;
      n_q      <= n_d;
      k_q      <= k_d;
      waddr_q  <= waddr_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
    end
  end

endmodule
